// File: rtl/mul_err_monitor.sv
// Error-statistics monitor for an 8x8 unsigned approximate multiplier.
// Accumulates |approx - exact| statistics over a window of 2^WIN_LOG2 samples.
//
// state | meaning
// IDLE  | waiting for start, no samples accepted
// RUN   | accepting samples until the window is full
// DRAIN | window full, letting the two pipeline stages empty
// DONE  | statistics valid and held until the next start
module mul_err_monitor #(
  parameter int WIN_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_a,
  input  logic [7:0]            in_b,
  input  logic [15:0]           in_o,
  output logic                  busy,
  output logic                  done,
  output logic [16+WIN_LOG2-1:0] sum_err,
  output logic [15:0]           max_err,
  output logic [7:0]            wce_a,
  output logic [7:0]            wce_b,
  output logic [WIN_LOG2:0]     err_cnt
);

  localparam logic [WIN_LOG2:0] WIN_CNT  = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [WIN_LOG2:0] LAST_CNT = {1'b0, {WIN_LOG2{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIN_LOG2:0] acc_cnt;
  logic              xfer;
  logic              start_ok;

  logic              v1;
  logic [7:0]        a1, b1;
  logic [15:0]       o1, p1;

  logic              v2;
  logic [7:0]        a2, b2;
  logic [15:0]       err2;

  logic [15:0]       exact;
  logic [16:0]       diff;
  logic [15:0]       abs_err;

  assign xfer     = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign exact    = {8'd0, in_a} * {8'd0, in_b};

  // Sign of the 17-bit difference selects which subtraction gives the magnitude.
  assign diff     = {1'b0, o1} - {1'b0, p1};
  assign abs_err  = diff[16] ? (p1 - o1) : diff[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = RUN;
      RUN:   if (xfer && (acc_cnt == LAST_CNT)) state_nxt = DRAIN;
      // Stage 2 is folded in on the same edge, so only stage 1 must be empty.
      DRAIN: if (!v1) state_nxt = DONE;
      DONE:  if (start_ok) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      RUN: begin
        in_ready = (acc_cnt < WIN_CNT);
        busy     = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt <= '0;
    end else if (start_ok) begin
      acc_cnt <= '0;
    end else if (xfer) begin
      acc_cnt <= acc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      o1 <= '0;
      p1 <= '0;
      v2 <= 1'b0;
      a2 <= '0;
      b2 <= '0;
      err2 <= '0;
    end else begin
      v1 <= xfer;
      if (xfer) begin
        a1 <= in_a;
        b1 <= in_b;
        o1 <= in_o;
        p1 <= exact;
      end
      v2 <= v1;
      if (v1) begin
        a2   <= a1;
        b2   <= b1;
        err2 <= abs_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      sum_err <= '0;
      max_err <= '0;
      wce_a   <= '0;
      wce_b   <= '0;
      err_cnt <= '0;
    end else if (v2) begin
      sum_err <= sum_err + {{WIN_LOG2{1'b0}}, err2};
      err_cnt <= err_cnt + {{WIN_LOG2{1'b0}}, (err2 != 16'd0)};
      // Strict compare keeps the earliest sample on ties.
      if (err2 > max_err) begin
        max_err <= err2;
        wce_a   <= a2;
        wce_b   <= b2;
      end
    end
  end

endmodule

// File: tb/tb_mul_err_monitor.sv
// Directed bench for mul_err_monitor with a 4-sample window.
// Table-driven windows plus hand sequences for backpressure, start and reset.
module tb_mul_err_monitor;

  localparam int WL = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      in_a = '0;
  logic [7:0]      in_b = '0;
  logic [15:0]     in_o = '0;
  logic            busy;
  logic            done;
  logic [16+WL-1:0] sum_err;
  logic [15:0]     max_err;
  logic [7:0]      wce_a;
  logic [7:0]      wce_b;
  logic [WL:0]     err_cnt;

  mul_err_monitor #(.WIN_LOG2(WL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .done(done),
    .sum_err(sum_err), .max_err(max_err),
    .wce_a(wce_a), .wce_b(wce_b), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [3:0][15:0] o;
    logic [31:0]      e_sum;
    logic [15:0]      e_max;
    logic [7:0]       e_wa;
    logic [7:0]       e_wb;
    logic [7:0]       e_cnt;
  } win_t;

  win_t tbl[4];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] o);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_o = o;
    chk("in_ready_before_xfer", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_stats(input string tag, input win_t w);
    chk({tag, "_sum_err"}, sum_err, w.e_sum);
    chk({tag, "_max_err"}, max_err, w.e_max);
    chk({tag, "_wce_a"}, wce_a, w.e_wa);
    chk({tag, "_wce_b"}, wce_b, w.e_wb);
    chk({tag, "_err_cnt"}, err_cnt, w.e_cnt);
  endtask

  task automatic run_window(input string tag, input win_t w);
    pulse_start();
    chk({tag, "_busy"}, busy, 1);
    for (int i = 0; i < 4; i++) send(w.a[i], w.b[i], w.o[i]);
    chk({tag, "_ready_after_last"}, in_ready, 0);
    tick();
    chk({tag, "_done_early"}, done, 0);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_in_done"}, busy, 0);
    check_stats(tag, w);
  endtask

  initial begin
    int xfers;
    // exact: 7*9 = 63 four times
    tbl[0] = '{a: {8'd7, 8'd7, 8'd7, 8'd7}, b: {8'd9, 8'd9, 8'd9, 8'd9},
               o: {16'd63, 16'd63, 16'd63, 16'd63},
               e_sum: 0, e_max: 0, e_wa: 0, e_wb: 0, e_cnt: 0};
    // mixed: errors 5, 0, 44, 5 (element [0] is sent first)
    tbl[1] = '{a: {8'd10, 8'd16, 8'd200, 8'd3}, b: {8'd10, 8'd16, 8'd100, 8'd5},
               o: {16'd95, 16'd300, 16'd20000, 16'd10},
               e_sum: 54, e_max: 44, e_wa: 16, e_wb: 16, e_cnt: 3};
    // worst case: 4 x 65025
    tbl[2] = '{a: {8'd255, 8'd255, 8'd255, 8'd255}, b: {8'd255, 8'd255, 8'd255, 8'd255},
               o: {16'd0, 16'd0, 16'd0, 16'd0},
               e_sum: 260100, e_max: 65025, e_wa: 255, e_wb: 255, e_cnt: 4};
    // errors 0, 5 (under), 5 (over, tie), 1: first max is (255,1)
    tbl[3] = '{a: {8'd1, 8'd0, 8'd255, 8'd2}, b: {8'd1, 8'd0, 8'd1, 8'd3},
               o: {16'd0, 16'd5, 16'd250, 16'd6},
               e_sum: 11, e_max: 5, e_wa: 255, e_wb: 1, e_cnt: 3};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    check_stats("rst", tbl[0]);

    for (int k = 0; k < 4; k++) run_window($sformatf("win%0d", k), tbl[k]);

    // start in DONE clears everything and reopens the window
    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_in_ready", in_ready, 1);
    check_stats("restart", tbl[0]);

    // tie and backpressure, with a start pulse during RUN that must be ignored
    xfers = 0;
    for (int cyc = 0; cyc < 40 && xfers < 4; cyc++) begin
      if (cyc % 2 == 1) begin
        in_valid = 1'b0;
        start = (cyc == 3);
      end else begin
        in_valid = 1'b1;
        in_a = (xfers % 2 == 0) ? 8'd3 : 8'd5;
        in_b = (xfers % 2 == 0) ? 8'd5 : 8'd3;
        in_o = 16'd10;
      end
      if (in_valid && in_ready) xfers++;
      tick();
      start = 1'b0;
    end
    chk("bp_transfers", xfers, 4);
    in_valid = 1'b1;
    in_a = 8'd9;
    in_b = 8'd9;
    in_o = 16'd0;
    chk("bp_ready_after_4th", in_ready, 0);
    tick();
    tick();
    chk("bp_done", done, 1);
    tick();
    tick();
    chk("bp_ready_held", in_ready, 0);
    check_stats("bp", '{a: '0, b: '0, o: '0, e_sum: 20, e_max: 5, e_wa: 3, e_wb: 5, e_cnt: 4});
    in_valid = 1'b0;

    // reset mid-window discards the partial window
    pulse_start();
    send(8'd255, 8'd255, 16'd0);
    send(8'd255, 8'd255, 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    check_stats("mid_rst", tbl[0]);
    tick();
    tick();
    tick();
    chk("mid_rst_idle_busy", busy, 0);
    chk("mid_rst_idle_sum", sum_err, 0);
    run_window("after_rst", tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mul_err_monitor.md
Name: mul_err_monitor

Overview:
- Downstream evaluation stage for the 8x8 unsigned approximate multipliers.
- Consumes operand pairs together with the approximate product the multiplier under test returned for them.
- Computes the exact product internally and accumulates error statistics over a window of 2^WIN_LOG2 samples: sum of absolute error, maximum absolute error with its operands, and count of erroneous samples.
- Results are handed to the characterisation flow when done is high.

Parameters:
- WIN_LOG2, 8, log2 of the window length in samples; legal range 1..16.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that clears statistics and opens a new window.
- in_valid  input  1  the sample on in_a/in_b/in_o is valid.
- in_ready  output  1  block accepts a sample this cycle.
- in_a  input  8  operand A.
- in_b  input  8  operand B.
- in_o  input  16  approximate product from the multiplier under test.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  window complete; statistics valid and held.
- sum_err  output  16+WIN_LOG2  sum of |in_o - in_a*in_b| over the window.
- max_err  output  16  largest absolute error in the window.
- wce_a  output  8  in_a of the first sample reaching max_err.
- wce_b  output  8  in_b of the first sample reaching max_err.
- err_cnt  output  WIN_LOG2+1  number of samples with nonzero error.

Behaviour:
- Reset (synchronous, active-high) forces the following on the next edge, regardless of state:
  - state IDLE;
  - all outputs 0 (in_ready, busy, done, sum_err, max_err, wce_a, wce_b, err_cnt);
  - pipeline valid bits cleared and accept counter 0.
  - Reset mid-window discards the partial window entirely.
- States:
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready=1 while the accept counter < 2^WIN_LOG2. A transfer occurs when in_valid & in_ready. The transfer of sample number 2^WIN_LOG2 -> DRAIN on the same edge; in_ready is 0 from the next cycle.
  - DRAIN: in_ready=0. Waits until both pipeline stages are empty, then enters DONE.
  - DONE: done=1 and statistics are held. start -> RUN.
- start handling:
  - Any start accepted in IDLE or DONE, on the same edge: clears sum_err, max_err, wce_a, wce_b, err_cnt, the accept counter and done.
  - start in RUN or DRAIN is ignored.
- Pipeline:
  - Stage 1 (transfer edge): registers a, b, o and the exact 16-bit product a*b, plus v1.
  - Stage 2 (next edge): registers abs_err = |o - exact| (16-bit unsigned, computed from a 17-bit signed difference), a, b, plus v2.
  - Accumulate (next edge, when v2): sum_err += abs_err; err_cnt += (abs_err != 0); if abs_err > max_err (strictly greater), max_err <= abs_err and wce_a/wce_b <= a/b.
  - Ties keep the earliest sample.
- Latency:
  - The last sample's error is folded in 2 edges after its transfer edge.
  - done rises on that same edge, so the final statistics and done=1 are visible together.
- Sample order and throughput:
  - Samples are processed strictly in transfer order.
  - Throughput is one sample per cycle with no bubbles inserted by the block.
  - in_valid gaps are tolerated without limit.
- Widths: sum_err cannot overflow, since (2^WIN_LOG2)·65535 < 2^(16+WIN_LOG2). err_cnt reaches 2^WIN_LOG2 at most.
- Excess input: inputs offered while in_ready=0 are not consumed and have no effect.

Test Plan:
- Exact window:
  - Stimulus: WIN_LOG2=2, start, then 4 samples each with in_o = a*b (e.g. 7·9=63).
  - Required: done=1 two edges after the 4th transfer; sum_err=0, max_err=0, err_cnt=0, wce_a=wce_b=0.
- Mixed errors:
  - Stimulus: WIN_LOG2=2, samples (3,5,10), (200,100,20000), (16,16,300), (10,10,95).
  - Required: sum_err=54, max_err=44, wce_a=16, wce_b=16, err_cnt=3.
- Worst case and no overflow:
  - Stimulus: WIN_LOG2=2, 4 × (255,255,0).
  - Required: sum_err=260100, max_err=65025, err_cnt=4, wce_a=wce_b=255.
- Tie and backpressure:
  - Stimulus: WIN_LOG2=2, samples (3,5,10) then (5,3,10) with in_valid toggled every other cycle; a 5th sample is held valid after the window.
  - Required: max_err=5 with wce_a=3, wce_b=5; in_ready=0 after the 4th transfer; the 5th sample is not consumed; err_cnt=4.
- Reset mid-window:
  - Stimulus: rst after 2 transfers.
  - Required: next cycle state IDLE, busy=0, done=0, in_ready=0, all statistics 0. A following start plus 4 exact samples gives done with sum_err=0.
- start handling:
  - Stimulus: start pulsed during RUN.
  - Required: no effect; counts continue.
  - Stimulus: start in DONE.
  - Required: next cycle done=0, statistics 0, in_ready=1.
